// File: rtl/sample_feeder_pkg.sv
// Shared defaults for the NISC input feeder and its sample FIFO.
package sample_feeder_pkg;

  localparam int unsigned FEED_DEPTH = 4;
  localparam int unsigned FEED_GAP   = 16;

endpackage

// File: rtl/sample_fifo.sv
// Small circular sample FIFO with a combinational head and an occupancy count.
module sample_fifo
  import sample_feeder_pkg::*;
#(
  parameter int unsigned n     = 8,
  parameter int unsigned DEPTH = FEED_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [n-1:0]                 wdata,
  output logic [n-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [n-1:0]  mem_q [DEPTH];
  logic [n-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d                = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    level = LW'(wptr_q - rptr_q);
    full  = (level == LW'(DEPTH));
    empty = (wptr_q == rptr_q);
    rdata = mem_q[rptr_q[AW-1:0]];
  end

endmodule

// File: rtl/sample_feeder.sv
// Buffers producer samples and releases them to the CPU inport at a paced rate,
// toggling a phase bit on every release.
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int unsigned n     = 8,
  parameter int unsigned DEPTH = FEED_DEPTH,
  parameter int unsigned GAP   = FEED_GAP
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [n-1:0]                 s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [n:0]                   inport,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overrun
);

  localparam int unsigned CW = $clog2(GAP + 1);

  logic [n-1:0]  hold_q, hold_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, overrun_d;
  logic          released_q, released_d;

  logic          fifo_full, fifo_empty;
  logic [n-1:0]  fifo_head;
  logic          push, pop, due;

  sample_fifo #(
    .n     (n),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (s_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    s_ready    = !reset && !fifo_full;
    push       = s_valid && s_ready;
    due        = (cnt_q == '0);
    pop        = due && !fifo_empty;
    hold_d     = hold_q;
    phase_d    = phase_q;
    cnt_d      = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    overrun_d  = overrun_q;
    released_d = released_q;
    if (pop) begin
      hold_d     = fifo_head;
      phase_d    = !phase_q;
      cnt_d      = CW'(GAP - 1);
      released_d = 1'b1;
    end else if (due && released_q) begin
      // Starvation before the first release is startup, not an overrun.
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= '0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
      released_q <= released_d;
    end
  end

  always_comb begin
    inport  = {phase_q, hold_q};
    overrun = overrun_q;
  end

endmodule
